dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path (byte access, 8-bit address) and the 256x8 data memory (4-byte block access, 6-bit block address).
- Serves hits without stalling; on a miss, stalls the CPU via busywait while it writes back a dirty victim and fetches the new block over the memory read/write/busywait handshake.
- Acts as the initiator for the data memory's responder interface.

---
 rtl/dcache_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for a byte-wide CPU port and a 32-bit block memory.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int TAG_W = 6 - INDEX_W;
  localparam int NBLK  = 1 << INDEX_W;

  // One-hot encoding so the memory strobes are single state bits and cannot glitch.
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    WRITEBACK = 4'b0010,
    FETCH     = 4'b0100,
    UPDATE    = 4'b1000
  } state_t;

  state_t state, state_next;

  logic [NBLK-1:0]  valid;
  logic [NBLK-1:0]  dirty;
  logic [TAG_W-1:0] tags [NBLK];
  logic [31:0]      data [NBLK];

  logic [TAG_W-1:0] tag_a;
  logic [INDEX_W-1:0] idx;
  logic [1:0]       off;
  logic [31:0]      blk;
  logic             access;
  logic             hit;
  logic             idle_hit;
  logic             wr_hit;

  assign off      = address[1:0];
  assign idx      = address[2 +: INDEX_W];
  assign tag_a    = address[7 -: TAG_W];
  assign blk      = data[idx];
  assign access   = read ^ write;
  assign hit      = valid[idx] && (tags[idx] == tag_a);
  assign idle_hit = (state == IDLE) && hit;
  assign wr_hit   = write && !read && idle_hit;

  // Reset gates the stall directly so the CPU is released the moment a transfer is aborted.
  assign busywait = access && !idle_hit && !reset;
  assign readdata = (read && !write && idle_hit) ? blk[{off, 3'b000} +: 8] : 8'h00;

  assign mem_write     = state[1];
  assign mem_read      = state[2];
  assign mem_writedata = state[1] ? blk : 32'h0;

  always_comb begin
    mem_address = 6'h00;
    if (state[1])
      mem_address = {tags[idx], idx};
    else if (state[2])
      mem_address = {tag_a, idx};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (access && !hit)
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        if (!mem_busywait)
          state_next = FETCH;
      end
      FETCH: begin
        if (!mem_busywait)
          state_next = UPDATE;
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone decides whether they mean anything.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data[idx] <= mem_readdata;
      tags[idx] <= tag_a;
    end else if (wr_hit) begin
      data[idx][{off, 3'b000} +: 8] <= writedata;
    end
  end

`ifdef CACHE_STATS_EN
  // from_miss marks the completing cycle of a refilled access so it is not also counted as a hit.
  logic from_miss;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
      from_miss  <= 1'b0;
    end else begin
      if (state == UPDATE)
        from_miss <= 1'b1;
      else if (state == IDLE)
        from_miss <= 1'b0;
      if ((state == IDLE) && access && hit && !from_miss && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'h0001;
      if ((state == IDLE) && access && !hit && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'h0001;
    end
  end
`endif

endmodule
